// File: rtl/avalon_sram_pkg.sv
// Shared types and constants for the Avalon SRAM read master.
package avalon_sram_pkg;

   typedef enum logic [1:0] {
      MASTER_IDLE,
      MASTER_ISSUE,
      MASTER_DRAIN
   } master_state_t;

   localparam int SRAM_DATA_WIDTH   = 16;
   localparam int AVALON_ADDR_WIDTH = 32;

   localparam logic [1:0] BE_ALL_N  = 2'b00;
   localparam logic [1:0] BE_NONE_N = 2'b11;

endpackage

// File: rtl/read_return_fifo.sv
// Return-data FIFO for the read master: synchronous, power-of-two depth,
// head word visible combinationally on data_o.
module read_return_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) begin
            rd_q <= rd_q + AW'(1);
         end
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   // The issue credit makes a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !pop_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/avalon_sram_read_master.sv
// Avalon-MM pipelined read initiator: fetches a block of 16-bit words
// and streams them out through a credit-limited return FIFO.
module avalon_sram_read_master
   import avalon_sram_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int MAX_PENDING = 4,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [AVALON_ADDR_WIDTH-1:0] cmd_address,
   input  logic [LEN_WIDTH-1:0]         cmd_length,
   output logic                         busy,
   output logic                         done,
   output logic                         protocol_err,
   output logic                         read_n,
   output logic                         write_n,
   output logic [AVALON_ADDR_WIDTH-1:0] address,
   output logic [1:0]                   byteEnable_n,
   input  logic                         waitrequest,
   input  logic                         readdatavalid,
   input  logic [SRAM_DATA_WIDTH-1:0]   readData,
   output logic [SRAM_DATA_WIDTH-1:0]   out_data,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int PW = $clog2(MAX_PENDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = ((PW > CW) ? PW : CW) + 1;

   master_state_t                state_q, state_d;
   logic                         read_n_q, read_n_d;
   logic [AVALON_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]         rem_q, rem_d;
   logic [PW-1:0]                pend_q, pend_d;
   logic                         done_q, done_d;
   logic                         perr_q, perr_d;
   logic [CW-1:0]                fifo_cnt, cnt_d;
   logic [SW-1:0]                credit;
   logic                         rd_acc, push, pop, issue_ok;

   assign rd_acc = !read_n_q && !waitrequest;
   assign push   = readdatavalid && (pend_q != '0);
   assign pop    = out_valid && out_ready;
   assign cnt_d  = fifo_cnt + CW'(push) - CW'(pop);
   assign pend_d = pend_q + PW'(rd_acc) - PW'(push);
   assign credit = SW'(pend_d) + SW'(cnt_d);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      perr_d  = perr_q | (readdatavalid && (pend_q == '0));
      unique case (state_q)
         MASTER_IDLE: begin
            if (cmd_valid) begin
               perr_d = 1'b0;
               addr_d = cmd_address;
               rem_d  = cmd_length;
               if (cmd_length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = MASTER_ISSUE;
               end
            end
         end
         MASTER_ISSUE: begin
            if (rd_acc) begin
               addr_d = addr_q + 32'd1;
               rem_d  = rem_q - LEN_WIDTH'(1);
            end
            if (rem_d == '0) begin
               state_d = MASTER_DRAIN;
            end
         end
         MASTER_DRAIN: begin
            if (pend_d == '0) begin
               done_d  = 1'b1;
               state_d = MASTER_IDLE;
            end
         end
         default: state_d = MASTER_IDLE;
      endcase
      // Credit uses next-cycle occupancy so throughput stays one word/cycle.
      issue_ok = (state_d == MASTER_ISSUE) && (rem_d != '0) &&
                 (pend_d < PW'(MAX_PENDING)) &&
                 (credit < SW'(FIFO_DEPTH));
      read_n_d = (!read_n_q && waitrequest) ? 1'b0 : !issue_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MASTER_IDLE;
         read_n_q <= 1'b1;
         addr_q   <= '0;
         rem_q    <= '0;
         pend_q   <= '0;
         done_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         read_n_q <= read_n_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         pend_q   <= pend_d;
         done_q   <= done_d;
         perr_q   <= perr_d;
      end
   end

   read_return_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SRAM_DATA_WIDTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (readData),
      .pop_i   (pop),
      .data_o  (out_data),
      .valid_o (out_valid),
      .count_o (fifo_cnt)
   );

   assign cmd_ready    = (state_q == MASTER_IDLE);
   assign busy         = (state_q != MASTER_IDLE);
   assign done         = done_q;
   assign protocol_err = perr_q;
   assign read_n       = read_n_q;
   assign write_n      = 1'b1;
   assign address      = addr_q;
   assign byteEnable_n = read_n_q ? BE_NONE_N : BE_ALL_N;

endmodule

// File: tb/tb_avalon_sram_read_master.sv
// Bench for avalon_sram_read_master: slave model, stream scoreboard,
// vector table, random commands and multi-cycle corner sequences.
module tb_avalon_sram_read_master;

   localparam int FIFO_DEPTH  = 8;
   localparam int MAX_PENDING = 4;
   localparam int LEN_WIDTH   = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [31:0]          cmd_address;
   logic [LEN_WIDTH-1:0] cmd_length;
   logic                 busy;
   logic                 done;
   logic                 protocol_err;
   logic                 read_n;
   logic                 write_n;
   logic [31:0]          address;
   logic [1:0]           byteEnable_n;
   logic                 waitrequest;
   logic                 readdatavalid;
   logic [15:0]          readData;
   logic [15:0]          out_data;
   logic                 out_valid;
   logic                 out_ready;

   always #5 clk = ~clk;

   avalon_sram_read_master #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .MAX_PENDING (MAX_PENDING),
      .LEN_WIDTH   (LEN_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_address   (cmd_address),
      .cmd_length    (cmd_length),
      .busy          (busy),
      .done          (done),
      .protocol_err  (protocol_err),
      .read_n        (read_n),
      .write_n       (write_n),
      .address       (address),
      .byteEnable_n  (byteEnable_n),
      .waitrequest   (waitrequest),
      .readdatavalid (readdatavalid),
      .readData      (readData),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   typedef struct {
      logic [15:0] d;
      int          due;
   } ret_t;

   typedef struct {
      logic [31:0] addr;
      int          len;
      int          lat;
      int          wait_pct;
      int          rdv_pct;
      int          rdy_pct;
      bit          b2b;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc_n   = 0;
   ret_t        sq[$];
   logic [31:0] exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   int          pend_m, fifo_m;
   bit          perr_m, hold_prev;
   logic [31:0] addr_prev;
   int          lat = 2, wait_pct = 0, rdv_pct = 100, rdy_pct = 100;
   bit          withhold = 0;
   int          rel_cnt = 0;
   int          wr_idx = -1, wr_left = 0;
   logic [31:0] watch_addr = 32'h0;
   int          watch_cnt = 0;
   int          acc_total = 0, acc_cmd = 0, done_cmd = 0;
   int          first_acc, last_acc, cacc_cyc, done_cyc;
   bit          cmd_taken;
   vec_t        vecs[7];

   function automatic logic [15:0] fdat(logic [31:0] a);
      return a[15:0] ^ a[31:16] ^ 16'h5A3C;
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   // Evaluate the current cycle, then advance to the next negedge and
   // drive the slave and sink for the new cycle.
   task automatic cyc();
      bit acc, pop, ret, cacc;
      acc  = !read_n && !waitrequest;
      pop  = out_valid && out_ready;
      ret  = readdatavalid;
      cacc = cmd_valid && cmd_ready;
      if (ret && sq.size() > 0) sq.delete(0);
      if (rst) begin
         exp_addr_q.delete();
         exp_data_q.delete();
         pend_m    = 0;
         fifo_m    = 0;
         perr_m    = 0;
         hold_prev = 0;
      end else begin
         chk("write_n", write_n, 1'b1);
         chk("byteEnable_n", byteEnable_n, read_n ? 2'b11 : 2'b00);
         chk("busy", busy, !cmd_ready);
         chk("out_valid", out_valid, fifo_m != 0);
         chk("protocol_err", protocol_err, perr_m);
         if (hold_prev) begin
            chk("hold_read_n", read_n, 1'b0);
            chk("hold_address", address, addr_prev);
         end
         if (done) begin
            done_cmd++;
            done_cyc = cyc_n;
            chk("done_with_pending", pend_m, 0);
         end
         if (!read_n && address == watch_addr) watch_cnt++;
         if (ret) begin
            if (pend_m > 0) begin
               pend_m--;
               fifo_m++;
               chk("fifo_bound", fifo_m <= FIFO_DEPTH, 1'b1);
            end else begin
               perr_m = 1;
            end
         end
         if (acc) begin
            chk("reads_left", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0)
               chk("read_addr", address, exp_addr_q.pop_front());
            sq.push_back('{fdat(address), cyc_n + lat});
            pend_m++;
            acc_cmd++;
            acc_total++;
            if (acc_cmd == 1) first_acc = cyc_n;
            last_acc = cyc_n;
            chk("pending_bound", pend_m <= MAX_PENDING, 1'b1);
         end
         if (pop) begin
            chk("words_left", exp_data_q.size() > 0, 1'b1);
            if (exp_data_q.size() > 0)
               chk("out_data", out_data, exp_data_q.pop_front());
            if (fifo_m > 0) fifo_m--;
         end
         if (cacc) begin
            for (int i = 0; i < int'(cmd_length); i++) begin
               exp_addr_q.push_back(cmd_address + 32'(i));
               exp_data_q.push_back(fdat(cmd_address + 32'(i)));
            end
            perr_m    = 0;
            acc_cmd   = 0;
            done_cmd  = 0;
            cacc_cyc  = cyc_n;
            cmd_taken = 1;
         end
         hold_prev = !read_n && waitrequest;
         addr_prev = address;
      end
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
      if (!read_n && wr_left > 0 && acc_total == wr_idx) begin
         waitrequest = 1'b1;
         wr_left--;
      end else begin
         waitrequest = (int'($urandom_range(99)) < wait_pct);
      end
      readdatavalid = 1'b0;
      readData      = 16'($urandom);
      if (sq.size() > 0 && sq[0].due <= cyc_n &&
          (!withhold || rel_cnt > 0) &&
          int'($urandom_range(99)) < rdv_pct) begin
         readdatavalid = 1'b1;
         readData      = sq[0].d;
         if (withhold) rel_cnt--;
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_read_n"}, read_n, 1'b1);
      chk({tag, "_write_n"}, write_n, 1'b1);
      chk({tag, "_address"}, address, 32'h0);
      chk({tag, "_byteEnable_n"}, byteEnable_n, 2'b11);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_protocol_err"}, protocol_err, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_data"}, out_data, 16'h0);
   endtask

   task automatic start_cmd(logic [31:0] a, int len);
      cmd_valid   = 1'b1;
      cmd_address = a;
      cmd_length  = LEN_WIDTH'(len);
      cmd_taken   = 0;
      for (int i = 0; i < 200 && !cmd_taken; i++) cyc();
      chk("cmd_accepted", cmd_taken, 1'b1);
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(int len, bit drain);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         cyc();
         ok = (done_cmd > 0) &&
              (!drain || (exp_data_q.size() == 0 && fifo_m == 0));
      end
      cyc();
      chk("cmd_finished", ok, 1'b1);
      chk("reads_issued", acc_cmd, len);
      chk("done_pulses", done_cmd, 1);
      chk("idle_after_done", busy, 1'b0);
   endtask

   task automatic run_vec(vec_t v);
      lat      = v.lat;
      wait_pct = v.wait_pct;
      rdv_pct  = v.rdv_pct;
      rdy_pct  = v.rdy_pct;
      start_cmd(v.addr, v.len);
      finish_cmd(v.len, 1'b1);
      if (v.b2b) chk("back_to_back", last_acc - first_acc, v.len - 1);
      if (v.len == 0) chk("len0_done_latency", done_cyc - cacc_cyc, 1);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0100, 4, 2, 0, 100, 100, 1'b1};
      vecs[1] = '{32'hFFFF_FFFE, 3, 1, 0, 100, 100, 1'b1};
      vecs[2] = '{32'h0000_0800, 0, 1, 0, 100, 100, 1'b0};
      vecs[3] = '{32'h0000_1234, 16, 3, 0, 100, 100, 1'b1};
      vecs[4] = '{32'h0000_2000, 12, 6, 0, 100, 100, 1'b0};
      vecs[5] = '{32'hABCD_0000, 9, 2, 40, 70, 60, 1'b0};
      vecs[6] = '{32'h7FFF_FFFF, 5, 1, 20, 50, 30, 1'b0};

      rst           = 1'b1;
      cmd_valid     = 1'b0;
      cmd_address   = '0;
      cmd_length    = '0;
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readData      = '0;
      out_ready     = 1'b0;
      repeat (3) cyc();
      chk_reset("reset");
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Three-cycle stall on the second read of a block.
      lat        = 2;
      wait_pct   = 0;
      rdv_pct    = 100;
      rdy_pct    = 100;
      watch_addr = 32'h101;
      watch_cnt  = 0;
      wr_idx     = acc_total + 1;
      wr_left    = 3;
      start_cmd(32'h100, 4);
      finish_cmd(4, 1'b1);
      chk("stall_hold_cycles", watch_cnt, 4);
      watch_addr = 32'hDEAD_BEEF;

      // Stream back-pressure limits issue to the FIFO depth.
      rdy_pct = 0;
      start_cmd(32'h300, 20);
      repeat (30) cyc();
      chk("credit_reads", acc_cmd, FIFO_DEPTH);
      chk("credit_read_n", read_n, 1'b1);
      rdy_pct = 100;
      finish_cmd(20, 1'b1);

      // Withheld returns limit issue to MAX_PENDING.
      lat      = 1;
      withhold = 1;
      rel_cnt  = 0;
      start_cmd(32'h400, 10);
      repeat (15) cyc();
      chk("pending_reads", acc_cmd, MAX_PENDING);
      chk("pending_read_n", read_n, 1'b1);
      rel_cnt = 1;
      repeat (8) cyc();
      chk("one_freed_read", acc_cmd, MAX_PENDING + 1);
      chk("one_freed_read_n", read_n, 1'b1);
      withhold = 0;
      finish_cmd(10, 1'b1);

      // Reset mid-transfer, then stray returns.
      withhold = 1;
      start_cmd(32'h500, 8);
      repeat (8) cyc();
      chk("busy_before_reset", busy, 1'b1);
      rst      = 1'b1;
      done_cmd = 0;
      repeat (2) cyc();
      chk_reset("midreset");
      rst      = 1'b0;
      withhold = 0;
      repeat (10) cyc();
      chk("stray_protocol_err", protocol_err, 1'b1);
      chk("no_done_after_reset", done_cmd, 0);
      chk("stray_dropped", out_valid, 1'b0);
      chk("stray_all_returned", sq.size(), 0);
      start_cmd(32'h40, 1);
      chk("perr_cleared", protocol_err, 1'b0);
      finish_cmd(1, 1'b1);

      // Random commands; odd ones start before the stream drains.
      for (int i = 0; i < 8; i++) begin
         vec_t v;
         v.addr     = $urandom;
         v.len      = int'($urandom_range(24, 1));
         v.lat      = int'($urandom_range(5, 1));
         v.wait_pct = int'($urandom_range(50));
         v.rdv_pct  = int'($urandom_range(100, 30));
         v.rdy_pct  = int'($urandom_range(100, 20));
         lat      = v.lat;
         wait_pct = v.wait_pct;
         rdv_pct  = v.rdv_pct;
         rdy_pct  = v.rdy_pct;
         start_cmd(v.addr, v.len);
         finish_cmd(v.len, i[0] == 1'b0);
      end
      rdy_pct = 100;
      for (int i = 0; i < 200 && fifo_m != 0; i++) cyc();
      cyc();
      chk("final_drain", exp_data_q.size(), 0);
      chk("final_out_valid", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/avalon_sram_read_master.md
Name: avalon_sram_read_master

Overview:
- Avalon-MM pipelined read initiator that fetches a block of 16-bit words from the SRAM slave into a local stream.
- Accepts a command (base word address, length) and issues back-to-back reads, honouring waitrequest.
- Tracks outstanding reads and buffers readdatavalid returns in a FIFO.
- Presents the data on a valid/ready stream to image-pipeline consumers.

Parameters:
FIFO_DEPTH, 8, return-data FIFO entries (power of two, >= MAX_PENDING)
MAX_PENDING, 4, maximum reads accepted by slave but not yet returned
LEN_WIDTH, 16, width of command length field (words)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high in IDLE; command accepted when cmd_valid && cmd_ready
cmd_address  input  32  first word address
cmd_length  input  LEN_WIDTH  number of words to read
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the last word of a command is in the FIFO
protocol_err  output  1  sticky: readdatavalid seen with zero pending
read_n  output  1  Avalon read, active low
write_n  output  1  Avalon write, constant 1
address  output  32  Avalon word address
byteEnable_n  output  2  2'b00 while read_n low, else 2'b11
waitrequest  input  1  slave stall
readdatavalid  input  1  return data valid
readData  input  16  return data
out_data  output  16  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready

Behaviour:
- Reset values: read_n=1, write_n=1, address=0, byteEnable_n=2'b11, cmd_ready=1, busy=0, done=0, protocol_err=0, out_valid=0, out_data=0.
- Reset clears pending, remaining and FIFO contents.
- Reset mid-transfer aborts the command with no done pulse.
- States:
  - IDLE: on command accept, latch address/length and go to ISSUE. If cmd_length==0, pulse done the next cycle and stay in IDLE. Accepting a command clears protocol_err.
  - ISSUE: drive reads until remaining==0, then go to DRAIN.
  - DRAIN: when pending==0, pulse done and go to IDLE.
- Issue rule (all registered):
  - Assert read_n=0 only if remaining>0, pending<MAX_PENDING and pending+fifo_count < FIFO_DEPTH, counting this cycle's accept.
  - Once asserted, read_n, address and byteEnable_n are held stable until a cycle with waitrequest=0.
  - Accept = !read_n && !waitrequest.
  - On accept: address+1 (wraps modulo 2^32), remaining-1, pending+1.
  - If credit still allows, read_n stays low next cycle for full throughput, one word/cycle.
- Return path:
  - readdatavalid pushes readData into the FIFO and does pending-1.
  - Accept and return in the same cycle leave pending unchanged.
  - readdatavalid with pending==0: data dropped, protocol_err set.
- FIFO: the credit rule guarantees no overflow; an overflow is an assertion failure.
- Stream:
  - out_valid = FIFO non-empty, registered output.
  - Pop on out_valid && out_ready.
  - Latency readdatavalid -> out_valid is 1 cycle; there is no bypass.
  - Simultaneous push/pop on an empty FIFO: the pushed word appears the next cycle.
  - out_data holds its value while out_valid && !out_ready.
- A new command may be accepted while the FIFO still holds data from the previous one; stream order is preserved.

Decomposition:
- Package avalon_sram_pkg holds:
  - master_state_t enum {MASTER_IDLE, MASTER_ISSUE, MASTER_DRAIN}
  - SRAM_DATA_WIDTH=16, AVALON_ADDR_WIDTH=32
  - BE_ALL_N=2'b00, BE_NONE_N=2'b11
- Sub-module: read_return_fifo, a synchronous FIFO with count output, parameterised depth/width.

Test Plan:
1. cmd_address=0x100, cmd_length=4, waitrequest=0, slave returns with 2-cycle latency, out_ready=1 -> reads at 0x100..0x103 on consecutive cycles, out_data in order, done pulse once, busy low after.
2. waitrequest high for 3 cycles during the 2nd read -> address held at 0x101 and read_n low throughout; no duplicate or skipped address.
3. out_ready=0, cmd_length=20, FIFO_DEPTH=8 -> at most 8 reads issued, read_n returns high, no FIFO overflow; releasing out_ready resumes issuing and yields all 20 words in order.
4. Slave withholds readdatavalid -> read_n deasserts after exactly MAX_PENDING=4 accepts; returning one word frees one issue.
5. cmd_address=0xFFFF_FFFE, length=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; cmd_length=0 -> done the next cycle, no read_n.
6. rst asserted mid-transfer, then a stray readdatavalid -> all outputs at reset values, no done; protocol_err=1; the next command accept clears it.
